// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-based in-order fetch into a DEPTH-entry {pc, inst} FIFO.
// Optional counters are enabled with `define FETCH_QUEUE_STATS_EN.
module fetch_queue #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_req_addr,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_rdata,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0] o_stat_redirects,
  output logic [31:0] o_stat_dropped,
  output logic [31:0] o_stat_starve
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q,   rsp_pc_d;
  logic [CW-1:0] count_q,    count_d;
  logic [CW-1:0] out_q,      out_d;
  logic [CW-1:0] drop_q,     drop_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic        credit_ok;
  logic        req_hs;
  logic        pop;
  logic        keep;
  logic        discard;
  logic [31:0] redirect_pc;
  logic        unused_redirect_lsbs;

  assign redirect_pc          = {i_redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

  // Credit: a request is only issued if a FIFO slot is already reserved for its response.
  assign credit_ok       = ({1'b0, count_q} + {1'b0, out_q}) < (CW + 1)'(DEPTH);
  assign o_mem_req_valid = ~i_rst & ~i_redirect & credit_ok;
  assign o_mem_req_addr  = fetch_pc_q;
  assign req_hs          = o_mem_req_valid & i_mem_req_ready;

  assign o_inst_valid = (count_q != '0);
  assign o_inst       = inst_mem_q[rd_ptr_q];
  assign o_inst_pc    = pc_mem_q[rd_ptr_q];
  assign pop          = o_inst_valid & i_inst_ready;

  // A response in a redirect cycle is stale by definition and never enters the FIFO.
  assign keep    = i_mem_rsp_valid & ~i_redirect & (drop_q == '0);
  assign discard = i_mem_rsp_valid & ~keep;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_d      = out_q + CW'(req_hs) - CW'(i_mem_rsp_valid);

    if (i_redirect) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      drop_d     = out_d;
    end else begin
      if (req_hs) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (i_mem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (keep) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(keep) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc_q <= RESET_ADDR;
      rsp_pc_q   <= RESET_ADDR;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is reset so the head outputs read as zero during and right after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (keep) begin
      pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
      inst_mem_q[wr_ptr_q] <= i_mem_rsp_rdata;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] redirects_q, redirects_d;
  logic [31:0] dropped_q,   dropped_d;
  logic [31:0] starve_q,    starve_d;

  always_comb begin
    redirects_d = redirects_q;
    dropped_d   = dropped_q;
    starve_d    = starve_q;
    if (i_redirect && (redirects_q != '1)) begin
      redirects_d = redirects_q + 32'd1;
    end
    if (discard && (dropped_q != '1)) begin
      dropped_d = dropped_q + 32'd1;
    end
    if (i_inst_ready && !o_inst_valid && (starve_q != '1)) begin
      starve_d = starve_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      redirects_q <= '0;
      dropped_q   <= '0;
      starve_q    <= '0;
    end else begin
      redirects_q <= redirects_d;
      dropped_q   <= dropped_d;
      starve_q    <= starve_d;
    end
  end

  assign o_stat_redirects = redirects_q;
  assign o_stat_dropped   = dropped_q;
  assign o_stat_starve    = starve_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

  a_credit : assert property (@(posedge i_clk) disable iff (i_rst)
    ({1'b0, count_q} + {1'b0, out_q}) <= (CW + 1)'(DEPTH));
  a_drop_le_out : assert property (@(posedge i_clk) disable iff (i_rst)
    drop_q <= out_q);
  a_no_orphan_rsp : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_mem_rsp_valid && (out_q == '0)));

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front end replacing the combinational imem port once the realistic memory arrives; sits directly upstream of hart.
- Issues in-order word fetches to a request/response instruction memory with variable latency, buffers returned words in a DEPTH-entry FIFO, and presents them to the hart with a PC via valid/ready.
- Handles control-flow redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
- RESET_ADDR, 32'h00000000, first fetch address after reset.
- DEPTH, 4, queue entries and maximum outstanding requests; power of 2, ≥2.

Ports:
- i_clk  input  1  global clock.
- i_rst  input  1  reset.
- o_mem_req_valid  output  1  fetch request valid.
- i_mem_req_ready  input  1  memory accepts request; handshake = valid & ready.
- o_mem_req_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
- i_mem_rsp_valid  input  1  response valid; responses return in request order, one per cycle maximum.
- i_mem_rsp_rdata  input  32  instruction word for the oldest outstanding request.
- o_inst_valid  output  1  queue head valid.
- i_inst_ready  input  1  hart consumes head this cycle.
- o_inst  output  32  head instruction word.
- o_inst_pc  output  32  head instruction address.
- i_redirect  input  1  control-flow change (taken branch, jump, trap).
- i_redirect_pc  input  32  new fetch address; bits [1:0] ignored (truncated to 0).

Interface decision:
- One clock; reset is asynchronous and active-high.
- Clock and reset ports are i_clk and i_rst.

Behaviour:
- State:
  - fetch_pc (32b).
  - FIFO of {pc, inst} with DEPTH entries, read/write pointers and count.
  - outstanding counter (clog2(DEPTH)+1 bits).
  - drop counter (same width).
- Reset (async, while i_rst = 1):
  - fetch_pc = RESET_ADDR; FIFO empty; outstanding = 0; drop = 0.
  - o_mem_req_valid = 0, o_inst_valid = 0.
  - o_mem_req_addr = RESET_ADDR; o_inst = 0; o_inst_pc = 0.
- Request issue:
  - o_mem_req_valid = ~i_rst & ~i_redirect & (count + outstanding < DEPTH). Credit scheme: every accepted request is guaranteed a FIFO slot.
  - o_mem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (wraps modulo 2^32); outstanding += 1.
  - The first request is presented in the first cycle after reset deasserts.
- Response:
  - Each i_mem_rsp_valid decrements outstanding.
  - If drop > 0: the word is discarded and drop -= 1.
  - Otherwise the word is pushed with pc = address of the matching request. Track a separate rsp_pc that increments by 4 per kept response and is reloaded on redirect.
- Output:
  - o_inst_valid = count != 0.
  - o_inst/o_inst_pc are driven from the registered FIFO head. There is no bypass, so a response in cycle N is visible at o_inst in cycle N+1.
  - Pop on o_inst_valid & i_inst_ready.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged. Legal at count = DEPTH because credit already reserved the slot.
  - Redirect in a cycle:
    - Next cycle: FIFO empty; fetch_pc = rsp_pc = {i_redirect_pc[31:2], 2'b00}.
    - drop = outstanding_next, i.e. outstanding + handshake − response; the handshake term is 0 because requests are blocked.
    - A response arriving in the redirect cycle is discarded and not counted into drop.
    - A pop in the redirect cycle is honoured (that instruction is consumed), then everything else is flushed.
  - Redirect while drop > 0: drop is recomputed as above; stale responses are never delivered.
- Reset mid-operation: all state cleared immediately. In-flight memory responses arriving after reset are not tracked. The memory is reset with the same i_rst, so none exist.
- Invariants (assert in sim):
  - count + outstanding ≤ DEPTH.
  - drop ≤ outstanding.
  - i_mem_rsp_valid is never asserted while outstanding = 0.

Optional Feature:
- Macro FETCH_QUEUE_STATS_EN.
- When defined, adds output ports:
  - o_stat_redirects (32b): count of i_redirect cycles.
  - o_stat_dropped (32b): count of discarded responses.
  - o_stat_starve (32b): cycles with i_inst_ready = 1 and o_inst_valid = 0.
- Counters saturate at 32'hFFFFFFFF and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, RESET_ADDR = 0x100, memory ready always, 1-cycle latency, i_inst_ready = 1 -> requests 0x100, 0x104, 0x108… on consecutive cycles; o_inst_pc sequence 0x100, 0x104… with one instruction per cycle after a 2-cycle fill.
- i_inst_ready = 0, DEPTH = 4 -> exactly 4 requests accepted, then o_mem_req_valid = 0. Raising ready pops 4 entries in order and requests resume.
- 3 requests outstanding (0x200–0x208, latency 5), redirect to 0x403 -> drop = 3, next request addr 0x400. The three old words never appear; first o_inst_pc = 0x400.
- Redirect in the same cycle as a response and a pop -> popped head consumed, response discarded, FIFO empty next cycle, o_inst_valid = 0.
- fetch_pc = 0xFFFFFFFC -> next request address 0x00000000 (wrap).
- Async i_rst pulse mid-burst, not clock aligned -> outputs drop to 0 immediately. After release, fetch restarts at RESET_ADDR with no stale instruction delivered.
